// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, issues word reads on the instruction bus and
// buffers fetched {pc, word} pairs in a small FIFO drained over valid/ready.
module instruction_fetch #(
    parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000,
    parameter int          DEPTH         = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_address,
    output logic [3:0]  bus_wstrobe,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_address,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        WAIT,
        FETCH,
        FLUSH
    } state_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic [31:0]      flush_address;
    logic [31:0]      fifo_pc   [DEPTH];
    logic [31:0]      fifo_word [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;
    logic             redirect_unused_bits;

    assign redirect_unused_bits = ^redirect_address[1:0];

    assign push       = (state == FETCH) && bus_ready && !redirect_valid;
    assign pop        = instr_valid && instr_ready;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    assign bus_valid   = (state != WAIT);
    assign bus_address = (state == FLUSH) ? flush_address : fetch_pc;
    assign bus_wstrobe = 4'b0000;
    assign bus_wdata   = 32'h0000_0000;

    // An empty FIFO presents zeros so the head never exposes unwritten storage.
    assign instr_valid = (count != '0);
    assign instr_data  = instr_valid ? fifo_word[rd_ptr] : 32'h0000_0000;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : 32'h0000_0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= WAIT;
            fetch_pc      <= RESET_ADDRESS;
            flush_address <= RESET_ADDRESS;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
        end else if (redirect_valid) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= {redirect_address[31:2], 2'b00};
            case (state)
                FETCH: begin
                    // A stalled request cannot be withdrawn: finish it at the old address.
                    if (!bus_ready) begin
                        state         <= FLUSH;
                        flush_address <= fetch_pc;
                    end else begin
                        state <= FETCH;
                    end
                end
                FLUSH:   state <= bus_ready ? FETCH : FLUSH;
                default: state <= FETCH;
            endcase
        end else begin
            count <= count_next;
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case (state)
                WAIT: begin
                    if (count < FULL) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus_ready) begin
                        state <= (count_next < FULL) ? FETCH : WAIT;
                    end
                end
                FLUSH: begin
                    if (bus_ready) begin
                        state <= FETCH;
                    end
                end
                default: state <= WAIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= fetch_pc;
            fifo_word[wr_ptr] <= bus_rdata;
        end
    end

endmodule
